// File: rtl/cpu_sequencer_if.sv
// Memory-side handshake bundle for the sequencer: instruction fetch port
// and data access port, each a held request completed by a one-cycle ack.
interface cpu_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I sequencer: owns PC and instruction register, walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB and parks in a sticky FAULT
// state on a memory wait timeout or a misaligned taken target.
// All strobes are registered from the next state so they line up exactly
// with the state they belong to and are clean zeros straight out of reset.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            reset,
  cpu_sequencer_if.master mem,
  output logic [31:0]     instr,
  input  logic            dec_branch,
  input  logic            dec_jump,
  input  logic            dec_load,
  input  logic            dec_store,
  input  logic            dec_regwrite,
  input  logic            br_taken,
  input  logic [31:0]     target_addr,
  output logic            rf_we,
  output logic [31:0]     pc,
  output logic            retire,
  output logic [31:0]     instret,
  output logic            fault,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  // Counter only ever holds 0..TIMEOUT-1; reaching the last value with no
  // ack is the timeout.
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       instret_q, instret_d;
  logic [31:0]       target_q, target_d;
  logic              taken_q, taken_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic              rf_we_q, rf_we_d;
  logic              retire_q, retire_d;
  logic              fault_q, fault_d;
  logic              taken_now;

  // Next-state, datapath register updates and registered strobe decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instret_d  = instret_q;
    target_d   = target_q;
    taken_d    = taken_q;
    cnt_d      = cnt_q;
    taken_now  = dec_jump | (dec_branch & br_taken);

    case (state_q)
      S_FETCH: begin
        // imem_req_q is low only in the first cycle after reset release.
        if (imem_req_q) begin
          if (mem.imem_ack) begin
            instr_d = mem.imem_rdata;
            state_d = S_DECODE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        taken_d  = taken_now;
        target_d = target_addr;
        if (taken_now && (target_addr[1:0] != 2'b00)) begin
          state_d = S_FAULT;
        end else if (dec_load || dec_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem.dmem_ack) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        pc_d      = taken_q ? target_q : pc_q + 32'd4;
        instret_d = instret_q + 32'd1;
        state_d   = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) & dec_store;
    rf_we_d    = (state_d == S_WB) & dec_regwrite & ~dec_store;
    retire_d   = (state_d == S_WB);
    fault_d    = (state_d == S_FAULT);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0000_0013;
      instret_q  <= 32'd0;
      target_q   <= 32'd0;
      taken_q    <= 1'b0;
      cnt_q      <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      retire_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instret_q  <= instret_d;
      target_q   <= target_d;
      taken_q    <= taken_d;
      cnt_q      <= cnt_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
      retire_q   <= retire_d;
      fault_q    <= fault_d;
    end
  end

  assign mem.imem_req  = imem_req_q;
  assign mem.imem_addr = pc_q;
  assign mem.dmem_req  = dmem_req_q;
  assign mem.dmem_we   = dmem_we_q;
  assign instr         = instr_q;
  assign pc            = pc_q;
  assign rf_we         = rf_we_q;
  assign retire        = retire_q;
  assign instret       = instret_q;
  assign fault         = fault_q;
  assign state         = state_q;

endmodule
